// File: rtl/sys_regs.sv
// sys_regs: CPU register window 0x2020-0x2027 with joypad port, IRQ timer/prescaler, IRQ status/ack, sys_ctl.
// Optional DMA interrupt path is built only when SYS_REGS_DMA_IRQ_EN is defined.
module sys_regs #(
    parameter int PRESCALE_FAST = 256,
    parameter int PRESCALE_SLOW = 16384
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_en,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] joystick,
    input  logic       dma_done,
    output logic [7:0] sys_ctl,
    output logic       irq
);

    localparam logic [13:0] FAST_RELOAD = 14'(PRESCALE_FAST - 1);
    localparam logic [13:0] SLOW_RELOAD = 14'(PRESCALE_SLOW - 1);

    logic        rd;
    logic        wr;
    logic        wr_timer;
    logic        wr_ctl;
    logic        rd_tim_ack;
    logic [13:0] presc;
    logic [13:0] presc_reload;
    logic        tdec;
    logic [7:0]  count;
    logic        tim_set;
    logic        tim_flag;
    logic        dma_flag;
    logic [7:0]  rd_data;
    logic        irq_next;

    assign rd         = cs & ~we;
    assign wr         = cs & we;
    assign wr_timer   = wr && (addr == 3'd3);
    assign wr_ctl     = wr && (addr == 3'd6);
    assign rd_tim_ack = rd && (addr == 3'd4);

    // Slow/fast selection is sampled only at reload, so a mode change waits for the current period.
    assign presc_reload = sys_ctl[4] ? SLOW_RELOAD : FAST_RELOAD;
    assign tdec         = tick_en && (presc == 14'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= FAST_RELOAD;
        end else if (wr_timer) begin
            presc <= presc_reload;
        end else if (tick_en) begin
            presc <= (presc == 14'd0) ? presc_reload : presc - 14'd1;
        end
    end

    // A CPU load beats a coincident decrement; loading zero raises the flag immediately.
    assign tim_set = wr_timer ? (din == 8'h00) : (tdec && (count == 8'd1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 8'h00;
        end else if (wr_timer) begin
            count <= din;
        end else if (tdec && (count != 8'h00)) begin
            count <= count - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tim_flag <= 1'b0;
        end else if (tim_set) begin
            tim_flag <= 1'b1;
        end else if (rd_tim_ack) begin
            tim_flag <= 1'b0;
        end
    end

`ifdef SYS_REGS_DMA_IRQ_EN
    logic rd_dma_ack;
    assign rd_dma_ack = rd && (addr == 3'd5);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_flag <= 1'b0;
        end else if (dma_done) begin
            dma_flag <= 1'b1;
        end else if (rd_dma_ack) begin
            dma_flag <= 1'b0;
        end
    end

    assign irq_next = (tim_flag & sys_ctl[1]) | (dma_flag & sys_ctl[2]);
`else
    logic unused_dma_done;
    assign unused_dma_done = dma_done;
    assign dma_flag        = 1'b0;
    assign irq_next        = tim_flag & sys_ctl[1];
`endif

    always_comb begin
        rd_data = 8'hFF;
        case (addr)
            3'd0:    rd_data = ~joystick;
            3'd3:    rd_data = count;
            3'd4:    rd_data = 8'h00;
            3'd5:    rd_data = 8'h00;
            3'd6:    rd_data = sys_ctl;
            3'd7:    rd_data = {6'b0, dma_flag, tim_flag};
            default: rd_data = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout <= 8'hFF;
        end else if (rd) begin
            dout <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sys_ctl <= 8'h00;
        end else if (wr_ctl) begin
            sys_ctl <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_next;
        end
    end

endmodule
